// File: rtl/seq_mult_if.sv
// Operand/result bundle between a multiply controller and seq_mult.
// Handshake: the controller raises start with operands while busy=0; the product is valid only in the single done cycle.
interface seq_mult_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier: one 2*WIDTH-bit adder, WIDTH iterations,
// signed operands handled as magnitudes with a final conditional negate.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult_if.slave  bus,
  output logic [1:0] dbg_state_o
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit magnitude.
  assign a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Multiplicand shifts left and multiplier shifts right, so bit i meets multiplicand << i.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.product  = product_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: directed handshake/timing scenarios on WIDTH=8 and WIDTH=4 instances plus a random sweep.
module tb_seq_mult;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg;
  logic [1:0] dbg4;

  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(W)) bus ();
  seq_mult_if #(.WIDTH(4)) bus4 ();

  seq_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg)
  );

  seq_mult #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus4),
    .dbg_state_o (dbg4)
  );

  logic [2*W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] ref_mult(input logic [7:0] x, input logic [7:0] y, input logic sm);
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    if (sm) begin
      sx = {{8{x[7]}}, x};
      sy = {{8{y[7]}}, y};
      return sx * sy;
    end
    return {8'h00, x} * {8'h00, y};
  endfunction

  // Called at a negedge; presents one start for one cycle, then scrambles the operand lines.
  task automatic drive_start(input logic [7:0] x, input logic [7:0] y, input logic sm,
                             input logic [15:0] e);
    bus.start       = 1'b1;
    bus.a           = x;
    bus.b           = y;
    bus.signed_mode = sm;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start       = 1'b0;
    bus.a           = 8'($urandom);
    bus.b           = 8'($urandom);
    bus.signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    bit err;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0 || dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset busy=%b done=%b product=%h state=%0d required 0/0/0/0",
               bus.busy, bus.done, bus.product, dbg);
    end
    err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus4.done !== 1'b0) err = 1'b1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL reset_idle done pulsed without start, required none");
    end
  endtask

  task automatic test_width4_unsigned;
    bit err;
    bus4.start = 1'b1; bus4.a = 4'hF; bus4.b = 4'hF; bus4.signed_mode = 1'b0;
    @(negedge clk);
    bus4.start = 1'b0; bus4.a = 4'h3; bus4.b = 4'h2;
    err = (bus4.busy !== 1'b1) || (bus4.done !== 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) err = 1'b1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL w4_busy busy/done wrong during run, required busy=1 done=0");
    end
    @(negedge clk);
    total++;
    if (bus4.done !== 1'b1 || bus4.busy !== 1'b0 || bus4.product !== 8'hE1) begin
      bad++;
      $display("FAIL w4_result done=%b busy=%b product=%h required 1/0/e1",
               bus4.done, bus4.busy, bus4.product);
    end
    @(negedge clk);
    total++;
    if (bus4.done !== 1'b0 || bus4.product !== 8'hE1) begin
      bad++;
      $display("FAIL w4_after done=%b product=%h required 0/e1", bus4.done, bus4.product);
    end
  endtask

  task automatic test_latency;
    bit err;
    logic [15:0] e;
    drive_start(8'd200, 8'd250, 1'b0, 16'hC350);
    err = (bus.busy !== 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.product !== 16'h0) err = 1'b1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL latency_run busy/done/product wrong in run, required 1/0/held 0");
    end
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.product !== e) begin
      bad++;
      $display("FAIL latency_done done=%b busy=%b product=%h required 1/0/%h",
               bus.done, bus.busy, bus.product, e);
    end
  endtask

  task automatic test_signed;
    logic [7:0]  ta[5];
    logic [7:0]  tb_v[5];
    logic        ts[5];
    logic [15:0] te[5];
    logic [15:0] e;
    bit seen;
    ta   = '{8'h80, 8'hFD, 8'h00, 8'hFF, 8'hFF};
    tb_v = '{8'h80, 8'h07, 8'hFF, 8'hFF, 8'hFF};
    ts   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    te   = '{16'h4000, 16'hFFEB, 16'h0000, 16'h0001, 16'hFE01};
    for (int i = 0; i < 5; i++) begin
      drive_start(ta[i], tb_v[i], ts[i], te[i]);
      wait_done(seen);
      e = exp_q.pop_front();
      total++;
      if (!seen || bus.product !== e) begin
        bad++;
        $display("FAIL directed[%0d] seen=%b product=%h required %h", i, seen, bus.product, e);
      end
    end
  endtask

  task automatic test_ignored_start;
    int dones;
    int at;
    logic [15:0] got;
    logic [15:0] e;
    dones = 0; at = 0; got = '0;
    drive_start(8'd12, 8'd10, 1'b0, 16'd120);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 4; i <= 24; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        at  = i;
        got = bus.product;
      end
    end
    e = exp_q.pop_front();
    total++;
    if (dones != 1 || at != 9 || got !== e) begin
      bad++;
      $display("FAIL ignored_start dones=%0d at=%0d product=%h required 1/9/%h", dones, at, got, e);
    end
  endtask

  task automatic test_async_reset;
    bit err;
    bit seen;
    logic [15:0] e;
    drive_start(8'd200, 8'd100, 1'b0, 16'd20000);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0 || dbg !== 2'd0) begin
      bad++;
      $display("FAIL async_reset busy=%b done=%b product=%h state=%0d required 0/0/0/0",
               bus.busy, bus.done, bus.product, dbg);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    err = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) err = 1'b1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL abort_no_done done seen after abort, required none");
    end
    drive_start(8'h55, 8'h33, 1'b0, 16'h10EF);
    wait_done(seen);
    e = exp_q.pop_front();
    total++;
    if (!seen || bus.product !== e) begin
      bad++;
      $display("FAIL after_abort seen=%b product=%h required %h", seen, bus.product, e);
    end
  endtask

  task automatic test_back_to_back;
    bit seen;
    int gap;
    logic [15:0] e;
    gap = 0;
    drive_start(8'd7, 8'd9, 1'b0, 16'd63);
    wait_done(seen);
    e = exp_q.pop_front();
    total++;
    if (!seen || bus.product !== e) begin
      bad++;
      $display("FAIL b2b_first seen=%b product=%h required %h", seen, bus.product, e);
    end
    drive_start(8'hF0, 8'h0F, 1'b1, 16'hFF10);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        gap = i;
        break;
      end
    end
    e = exp_q.pop_front();
    total++;
    if (gap != 9 || bus.product !== e) begin
      bad++;
      $display("FAIL b2b_second cycles=%0d product=%h required 10/%h", gap + 1, bus.product, e);
    end
  endtask

  task automatic test_random;
    logic [7:0] x;
    logic [7:0] y;
    logic sm;
    logic [15:0] e;
    bit seen;
    for (int n = 0; n < 1000; n++) begin
      x  = 8'($urandom);
      y  = 8'($urandom);
      sm = 1'($urandom_range(0, 1));
      drive_start(x, y, sm, ref_mult(x, y, sm));
      wait_done(seen);
      e = exp_q.pop_front();
      total++;
      if (!seen || bus.product !== e || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL rand[%0d] a=%h b=%h sm=%0d seen=%b busy=%b product=%h required %h",
                 n, x, y, sm, seen, bus.busy, bus.product, e);
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_width4_unsigned();
    test_latency();
    test_signed();
    test_ignored_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-and-add multiplier with a start/done handshake and selectable signed or unsigned operation. It is the multi-cycle, width-generic successor to the team's 4x4 combinational array multiplier. It lets datapaths multiply WIDTH-bit operands with one adder instead of WIDTH-1 ripple adders. It sits between a controller that issues operands and a consumer that samples the 2*WIDTH-bit product on `done`.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: request a multiply; sampled on a rising edge when `busy`=0.
- `signed_mode`  input  1: 1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `a`  input  WIDTH: multiplicand; sampled with `start`.
- `b`  input  WIDTH: multiplier; sampled with `start`.
- `busy`  output  1: high while an operation is in progress.
- `done`  output  1: one-cycle pulse; `product` is valid in this cycle.
- `product`  output  2*WIDTH: result; held until the next accepted `start` completes.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on `start`=1, the block latches `signed_mode`, the operands and the result sign, then moves to RUN.
  - Signed mode: latch |a| and |b| as WIDTH-bit unsigned magnitudes. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits. Result sign = a[MSB] XOR b[MSB].
  - Unsigned mode: latch a and b unchanged. Result sign = 0.
  - Clear the 2*WIDTH-bit accumulator and the iteration counter.
- RUN: runs exactly WIDTH iterations, one per cycle, LSB of the multiplier first.
  - If the current multiplier bit is 1, add (multiplicand << i) into the accumulator.
  - The adder width is 2*WIDTH. No overflow can occur.
  - The counter is $clog2(WIDTH+1) bits and runs 0..WIDTH-1. After the iteration with count=WIDTH-1, go to FIX.
- FIX: write `product` = sign ? (-acc mod 2^(2*WIDTH)) : acc. Pulse `done`, then return to IDLE.
- `start` while `busy`=1 is ignored. It is not queued, and the operands in flight are unaffected.
- Input changes after acceptance have no effect on the current operation.
- `product` changes only in FIX. During RUN it holds the previous result.
- Signed range check: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) is representable. Every product fits in 2*WIDTH bits, so there is no saturation.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, state=IDLE, accumulator=0, counter=0.
- Reset is asynchronous: asserting `rst` mid-operation aborts the operation immediately, with no `done`.
- Let E0 be the edge that accepts `start`.
  - `busy` is high from E0 through E(WIDTH+1).
  - RUN iterations occur at E1..E(WIDTH).
  - FIX occurs at E(WIDTH+1).
  - After E(WIDTH+1), `done`=1 and `product` is valid for one cycle; `busy` is already 0 in that cycle.
- Latency is WIDTH+1 cycles from the accepting edge to the `done` cycle.
- Throughput: a new `start` may be accepted at E(WIDTH+2), i.e. in the same cycle `done` is high. That gives back-to-back operations every WIDTH+2 cycles.
- `done` never stays high for two consecutive cycles, except across back-to-back operations.
- `busy` and `done` are never both 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst` for 3 cycles, then release → `busy`=0, `done`=0, `product`=0; no `done` pulse without `start`.
- WIDTH=4, unsigned: a=15, b=15, start at E0 → `done` one cycle after E5, `product`=0xE1 (225), `busy` high only for E0..E5.
- WIDTH=8, signed:
  - a=0x80 (-128), b=0x80 → `product`=0x4000 (16384).
  - a=0xFD (-3), b=0x07 → `product`=0xFFEB (-21).
  - a=0, b=0xFF → `product`=0.
- WIDTH=8: start a=12, b=10 unsigned, then pulse `start` with a=1, b=1 at E3 → the second start is ignored; `product`=120 after 9 cycles; exactly one `done`.
- WIDTH=8: assert `rst` asynchronously (mid-cycle) at E4 of an operation → `busy`, `done` and `product` go to 0 before the next edge; no `done` afterwards; the next operation computes correctly.
- WIDTH=8, back-to-back: assert `start` in the `done` cycle with new operands → accepted; second `done` 10 cycles after the first. Finish with a 1000-vector random unsigned/signed sweep checked against a behavioural reference model.
